memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Fourth stage of the 5-stage MIPS pipeline, directly downstream of the Execute stage.
- Consumes the EX/MEM bundle: ALU result, store data, destination register, control bits, zero flag and branch target PC.
- Contains the word-addressed data RAM, resolves branches (PCSrc) and drives the MEM/WB pipeline register.
- Models a configurable multi-cycle memory access with a stall handshake to the upstream stages.

Parameters:
- DATA_ADDR_W, 8, word-address width; RAM depth = 2**DATA_ADDR_W words of 32 bits.
- MEM_LATENCY, 1, total cycles per load/store; legal range 1..15.

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- inBranch  in  1  EX/MEM branch control.
- inMemRead  in  1  EX/MEM load control.
- inMemWrite  in  1  EX/MEM store control.
- inMemToReg  in  1  EX/MEM writeback-select control.
- inRegWrite  in  1  EX/MEM register-write control.
- inZero  in  1  ALU zero flag.
- inPC  in  10  branch target PC.
- inAluResult  in  32  ALU result / byte address.
- inData2  in  32  store data.
- inWr  in  5  destination register.
- outPCSrc  out  1  branch taken.
- outBranchPC  out  10  branch target to fetch.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- outReadData  out  32  MEM/WB load data.
- outAluResult  out  32  MEM/WB ALU result.
- outWr  out  5  MEM/WB destination register.
- outMemToReg  out  1  MEM/WB control.
- outRegWrite  out  1  MEM/WB control.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset values:
  - outReadData, outAluResult, outWr, outMemToReg and outRegWrite are 0.
  - FSM is IDLE and the latency counter is 0.
  - RAM contents are not cleared; RAM is initialised to 0 at time zero.
- Addressing: word index = inAluResult[DATA_ADDR_W+1:2]. Bits [1:0] and all higher bits are ignored, so out-of-range addresses wrap.
- Access: access = inMemRead | inMemWrite. If both are set, the write wins and the load data is 0.
- Branch:
  - outPCSrc = inBranch & inZero, combinational.
  - outBranchPC = inPC, combinational.
  - Both are independent of the FSM.
- MEM_LATENCY = 1:
  - No stall.
  - A store writes inData2 at the rising edge.
  - A load captures RAM[index] into outReadData at the same edge, giving 1-cycle latency from EX/MEM to MEM/WB.
- MEM_LATENCY > 1, FSM IDLE/BUSY:
  - IDLE with access: stall=1 combinationally, cnt := MEM_LATENCY-2, next state BUSY if MEM_LATENCY>2, else DONE-cycle.
  - BUSY: stall=1 while cnt != 0; cnt decrements each edge.
  - Final cycle (cnt==0, or IDLE→final when MEM_LATENCY=2): stall=0.
  - At the final edge the access is performed and the MEM/WB register is loaded; the FSM returns to IDLE.
  - stall is high for exactly MEM_LATENCY-1 cycles per access.
  - Upstream holds the EX/MEM inputs stable while stall=1.
- Bubble: at every edge where stall=1, MEM/WB loads a bubble: outRegWrite=0, outMemToReg=0; other fields hold.
- Non-access instruction: MEM/WB loads inAluResult, inWr and the controls each edge; outReadData := 0.
- Store exactly-once: a store writes the RAM once, at its final edge only.
- Reset mid-access: the FSM returns to IDLE, the pending store is not performed, and stall drops the next cycle.
- Back-to-back loads/stores: each incurs the full latency; the IDLE→access decision is re-evaluated on the cycle after the final edge.

Optional Feature:
- Macro MEM_DEBUG_PORT_EN.
- When defined, adds two ports:
  - dbgAddr  in  DATA_ADDR_W
  - dbgData  out  32
- dbgData = RAM[dbgAddr], asynchronous read, for the UART memory-dump path. It never stalls or affects pipeline accesses.
- When undefined, the ports and logic are absent and the pipeline behaviour is identical.

Test Plan:
1. MEM_LATENCY=1, store inAluResult=0x8, inData2=0xDEADBEEF, then load 0x8 with inWr=5, inRegWrite=1, inMemToReg=1 → next edge outReadData=0xDEADBEEF, outWr=5, outRegWrite=1; stall never asserts.
2. inBranch=1, inZero=1, inPC=0x3C → outPCSrc=1, outBranchPC=0x3C the same cycle; with inZero=0 → outPCSrc=0.
3. MEM_LATENCY=3, load from 0x8 → stall=1 for exactly 2 cycles, outRegWrite=0 on those edges, then outReadData=0xDEADBEEF and outRegWrite=1 after the 3rd edge.
4. MEM_LATENCY=3, store 0x55 to 0x10, reset asserted in cycle 2 → stall=0 after reset, outputs 0, and a later load of 0x10 returns 0.
5. ALU op (inAluResult=7, inWr=2, inRegWrite=1, no access) → next edge outAluResult=7, outWr=2, outReadData=0; inMemRead=inMemWrite=1 at 0x4 with data 9 → RAM[1]=9, outReadData=0.
6. MEM_DEBUG_PORT_EN defined: after the store in test 1, dbgAddr=2 → dbgData=0xDEADBEEF combinationally.

Source files
------------

// File: rtl/memory_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_stage_if
// Brief    : EX/MEM inputs and MEM/WB, branch and stall outputs of the MEM stage
// Revision : 1.0
// ============================================================================
interface memory_stage_if;
  logic        inBranch;
  logic        inMemRead;
  logic        inMemWrite;
  logic        inMemToReg;
  logic        inRegWrite;
  logic        inZero;
  logic [9:0]  inPC;
  logic [31:0] inAluResult;
  logic [31:0] inData2;
  logic [4:0]  inWr;
  logic        outPCSrc;
  logic [9:0]  outBranchPC;
  logic        stall;
  logic [31:0] outReadData;
  logic [31:0] outAluResult;
  logic [4:0]  outWr;
  logic        outMemToReg;
  logic        outRegWrite;

  modport master (
    output inBranch, inMemRead, inMemWrite, inMemToReg, inRegWrite, inZero,
           inPC, inAluResult, inData2, inWr,
    input  outPCSrc, outBranchPC, stall, outReadData, outAluResult, outWr,
           outMemToReg, outRegWrite
  );

  modport slave (
    input  inBranch, inMemRead, inMemWrite, inMemToReg, inRegWrite, inZero,
           inPC, inAluResult, inData2, inWr,
    output outPCSrc, outBranchPC, stall, outReadData, outAluResult, outWr,
           outMemToReg, outRegWrite
  );
endinterface
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : memory_stage
// Brief    : MIPS MEM stage: data RAM, branch resolve, multi-cycle stall, MEM/WB
// Options  : MEM_DEBUG_PORT_EN adds async dbgAddr/dbgData RAM read port
// Revision : 1.0
// ============================================================================
module memory_stage #(
  parameter int DATA_ADDR_W = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  memory_stage_if.slave          bus
`ifdef MEM_DEBUG_PORT_EN
  ,
  input  logic [DATA_ADDR_W-1:0] dbgAddr,
  output logic [31:0]            dbgData
`endif
);
  localparam int c_DEPTH = 2 ** DATA_ADDR_W;

  logic [31:0] r_ram [c_DEPTH] = '{default: 32'h0};

  logic [DATA_ADDR_W-1:0] w_idx;
  logic                   w_access;
  logic                   w_load;
  logic                   w_stall;
  logic                   w_unused;

  logic [31:0] r_read_data;
  logic [31:0] r_alu_result;
  logic [4:0]  r_wr;
  logic        r_mem_to_reg;
  logic        r_reg_write;

  assign w_idx    = bus.inAluResult[DATA_ADDR_W+1:2];
  assign w_unused = ^{bus.inAluResult[31:DATA_ADDR_W+2], bus.inAluResult[1:0]};
  assign w_access = bus.inMemRead | bus.inMemWrite;
  assign w_load   = bus.inMemRead & ~bus.inMemWrite;

  generate
    if (MEM_LATENCY > 1) begin : g_multi
      typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
      localparam logic [3:0] c_CNT_INIT = 4'(MEM_LATENCY - 2);

      state_t     r_state;
      logic [3:0] r_cnt;

      // BUSY with cnt==0 is the final, non-stalled cycle of the access
      assign w_stall = (r_state == S_IDLE) ? w_access : (r_cnt != 4'd0);

      always_ff @(posedge clock) begin
        if (reset) begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end else if (r_state == S_IDLE) begin
          if (w_access) begin
            r_state <= S_BUSY;
            r_cnt   <= c_CNT_INIT;
          end
        end else if (r_cnt == 4'd0) begin
          r_state <= S_IDLE;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end else begin : g_single
      assign w_stall = 1'b0;
    end
  endgenerate

  // Stores commit only on the non-stalled (final) edge, so each is performed once
  always_ff @(posedge clock) begin
    if (!reset && !w_stall && bus.inMemWrite) begin
      r_ram[w_idx] <= bus.inData2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_read_data  <= 32'h0;
      r_alu_result <= 32'h0;
      r_wr         <= 5'd0;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
    end else if (w_stall) begin
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
    end else begin
      r_read_data  <= w_load ? r_ram[w_idx] : 32'h0;
      r_alu_result <= bus.inAluResult;
      r_wr         <= bus.inWr;
      r_mem_to_reg <= bus.inMemToReg;
      r_reg_write  <= bus.inRegWrite;
    end
  end

  assign bus.outPCSrc     = bus.inBranch & bus.inZero;
  assign bus.outBranchPC  = bus.inPC;
  assign bus.stall        = w_stall;
  assign bus.outReadData  = r_read_data;
  assign bus.outAluResult = r_alu_result;
  assign bus.outWr        = r_wr;
  assign bus.outMemToReg  = r_mem_to_reg;
  assign bus.outRegWrite  = r_reg_write;

`ifdef MEM_DEBUG_PORT_EN
  assign dbgData = r_ram[dbgAddr];
`endif
endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_stage
// Brief    : Bench for memory_stage at MEM_LATENCY 1 and 3 (MEM_DEBUG_PORT_EN aware)
// Revision : 1.0
// ============================================================================
module tb_memory_stage;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  memory_stage_if b1 ();
  memory_stage_if b3 ();

`ifdef MEM_DEBUG_PORT_EN
  logic [7:0]  dbg_addr1, dbg_addr3;
  logic [31:0] dbg_data1, dbg_data3;
`endif

  memory_stage #(.DATA_ADDR_W(8), .MEM_LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset), .bus(b1)
`ifdef MEM_DEBUG_PORT_EN
    , .dbgAddr(dbg_addr1), .dbgData(dbg_data1)
`endif
  );

  memory_stage #(.DATA_ADDR_W(8), .MEM_LATENCY(3)) u_l3 (
    .clock(clock), .reset(reset), .bus(b3)
`ifdef MEM_DEBUG_PORT_EN
    , .dbgAddr(dbg_addr3), .dbgData(dbg_data3)
`endif
  );

  typedef struct {
    logic        br, zero, mr, mw, m2r, rw;
    logic [9:0]  pc;
    logic [31:0] alu, d2;
    logic [4:0]  wr;
    logic        pcsrc_e;
    logic [31:0] rd_e;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [31:0] m3 [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(logic br, logic zero, logic mr, logic mw, logic m2r, logic rw,
                               logic [9:0] pc, logic [31:0] alu, logic [31:0] d2,
                               logic [4:0] wr, logic pcs, logic [31:0] rd);
    vec_t v;
    v.br = br; v.zero = zero; v.mr = mr; v.mw = mw; v.m2r = m2r; v.rw = rw;
    v.pc = pc; v.alu = alu; v.d2 = d2; v.wr = wr; v.pcsrc_e = pcs; v.rd_e = rd;
    return v;
  endfunction

  task automatic drive1(input vec_t v);
    b1.inBranch = v.br; b1.inZero = v.zero; b1.inMemRead = v.mr; b1.inMemWrite = v.mw;
    b1.inMemToReg = v.m2r; b1.inRegWrite = v.rw; b1.inPC = v.pc;
    b1.inAluResult = v.alu; b1.inData2 = v.d2; b1.inWr = v.wr;
  endtask

  task automatic drive3(input vec_t v);
    b3.inBranch = v.br; b3.inZero = v.zero; b3.inMemRead = v.mr; b3.inMemWrite = v.mw;
    b3.inMemToReg = v.m2r; b3.inRegWrite = v.rw; b3.inPC = v.pc;
    b3.inAluResult = v.alu; b3.inData2 = v.d2; b3.inWr = v.wr;
  endtask

  // Entered and left at a falling edge; counts stalled cycles of one instruction
  task automatic run3(input vec_t v, input int exp_st);
    int ns;
    bit done;
    ns = 0;
    done = 0;
    drive3(v);
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      chk("l3_pcsrc", {31'd0, b3.outPCSrc}, {31'd0, v.pcsrc_e});
      if (b3.stall) begin
        ns++;
        @(posedge clock); #1;
        chk("l3_bubble_rw", {31'd0, b3.outRegWrite}, 32'd0);
        chk("l3_bubble_m2r", {31'd0, b3.outMemToReg}, 32'd0);
        @(negedge clock);
      end else begin
        @(posedge clock); #1;
        chk("l3_rd", b3.outReadData, v.rd_e);
        chk("l3_alu", b3.outAluResult, v.alu);
        chk("l3_wr", {27'd0, b3.outWr}, {27'd0, v.wr});
        chk("l3_rw", {31'd0, b3.outRegWrite}, {31'd0, v.rw});
        chk("l3_m2r", {31'd0, b3.outMemToReg}, {31'd0, v.m2r});
        @(negedge clock);
        done = 1;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL l3_timeout: got stall stuck expected release");
    end
    chk("l3_stall_cycles", ns, exp_st);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [9];
    vec_t nop;
    vec_t v;
    int op, idx;
    logic [31:0] alu, d2, rd;
    logic mr, mw;

    for (int i = 0; i < 256; i++) m3[i] = 32'h0;
    nop = mkv(0, 0, 0, 0, 0, 0, 10'h0, 32'h0, 32'h0, 5'd0, 0, 32'h0);

    tbl[0] = mkv(0, 0, 0, 1, 0, 0, 10'h0,  32'h8,   32'hDEADBEEF, 5'd0, 0, 32'h0);
    tbl[1] = mkv(0, 0, 1, 0, 1, 1, 10'h0,  32'h8,   32'h0,        5'd5, 0, 32'hDEADBEEF);
    tbl[2] = mkv(1, 1, 0, 0, 0, 1, 10'h3C, 32'h7,   32'h0,        5'd2, 1, 32'h0);
    tbl[3] = mkv(1, 0, 0, 0, 0, 1, 10'h3C, 32'h7,   32'h0,        5'd2, 0, 32'h0);
    tbl[4] = mkv(0, 0, 1, 1, 0, 0, 10'h0,  32'h4,   32'h9,        5'd0, 0, 32'h0);
    tbl[5] = mkv(0, 0, 1, 0, 1, 1, 10'h0,  32'h4,   32'h0,        5'd1, 0, 32'h9);
    tbl[6] = mkv(0, 0, 1, 0, 1, 1, 10'h0,  32'h408, 32'h0,        5'd3, 0, 32'hDEADBEEF);
    tbl[7] = mkv(0, 0, 1, 0, 1, 1, 10'h0,  32'hB,   32'h0,        5'd4, 0, 32'hDEADBEEF);
    tbl[8] = mkv(0, 0, 1, 0, 1, 1, 10'h0,  32'h3FC, 32'h0,        5'd6, 0, 32'h0);

    reset = 1'b1;
    drive1(nop);
    drive3(nop);
`ifdef MEM_DEBUG_PORT_EN
    dbg_addr1 = 8'd0;
    dbg_addr3 = 8'd0;
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_l1_rd", b1.outReadData, 32'h0);
    chk("rst_l1_rw", {31'd0, b1.outRegWrite}, 32'd0);
    chk("rst_l1_stall", {31'd0, b1.stall}, 32'd0);
    chk("rst_l3_alu", b3.outAluResult, 32'h0);
    chk("rst_l3_wr", {27'd0, b3.outWr}, 32'd0);
    chk("rst_l3_stall", {31'd0, b3.stall}, 32'd0);
    @(negedge clock);

    for (int i = 0; i < 9; i++) begin
      drive1(tbl[i]);
      #1;
      chk("l1_pcsrc", {31'd0, b1.outPCSrc}, {31'd0, tbl[i].pcsrc_e});
      chk("l1_branchpc", {22'd0, b1.outBranchPC}, {22'd0, tbl[i].pc});
      chk("l1_stall", {31'd0, b1.stall}, 32'd0);
      @(posedge clock); #1;
      chk("l1_rd", b1.outReadData, tbl[i].rd_e);
      chk("l1_alu", b1.outAluResult, tbl[i].alu);
      chk("l1_wr", {27'd0, b1.outWr}, {27'd0, tbl[i].wr});
      chk("l1_rw", {31'd0, b1.outRegWrite}, {31'd0, tbl[i].rw});
      chk("l1_m2r", {31'd0, b1.outMemToReg}, {31'd0, tbl[i].m2r});
      @(negedge clock);
    end
    drive1(nop);

`ifdef MEM_DEBUG_PORT_EN
    dbg_addr1 = 8'd2;
    #1;
    chk("dbg_l1_idx2", dbg_data1, 32'hDEADBEEF);
    dbg_addr1 = 8'd1;
    #1;
    chk("dbg_l1_idx1", dbg_data1, 32'h9);
    @(negedge clock);
`endif

    run3(mkv(0, 0, 0, 1, 0, 0, 10'h0, 32'h8, 32'hDEADBEEF, 5'd0, 0, 32'h0), 2);
    m3[2] = 32'hDEADBEEF;
    run3(mkv(0, 0, 1, 0, 1, 1, 10'h0, 32'h8, 32'h0, 5'd5, 0, 32'hDEADBEEF), 2);

    // Reset lands in the second stalled cycle of a store to 0x10
    drive3(mkv(0, 0, 0, 1, 0, 0, 10'h0, 32'h10, 32'h55, 5'd0, 0, 32'h0));
    #1;
    chk("rstmid_stall1", {31'd0, b3.stall}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    drive3(nop);
    #1;
    chk("rstmid_stall", {31'd0, b3.stall}, 32'd0);
    chk("rstmid_rd", b3.outReadData, 32'h0);
    chk("rstmid_alu", b3.outAluResult, 32'h0);
    chk("rstmid_rw", {31'd0, b3.outRegWrite}, 32'd0);
    @(negedge clock);
    run3(mkv(0, 0, 1, 0, 1, 1, 10'h0, 32'h10, 32'h0, 5'd7, 0, 32'h0), 2);
    run3(mkv(1, 1, 0, 0, 0, 1, 10'h3C, 32'h7, 32'h0, 5'd2, 1, 32'h0), 0);

    for (int n = 0; n < 60; n++) begin
      op  = int'($urandom_range(0, 3));
      mr  = (op == 1) || (op == 3);
      mw  = (op == 2) || (op == 3);
      alu = ($urandom() & 32'hFFFF_FC00) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      d2  = $urandom();
      idx = int'((alu / 4) % 256);
      rd  = (mr && !mw) ? m3[idx] : 32'h0;
      if (mw) m3[idx] = d2;
      v = mkv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mr, mw,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              10'($urandom()), alu, d2, 5'($urandom()), 1'b0, rd);
      v.pcsrc_e = v.br && v.zero;
      run3(v, (mr || mw) ? 2 : 0);
    end
    drive3(nop);

`ifdef MEM_DEBUG_PORT_EN
    for (int i = 0; i < 8; i++) begin
      dbg_addr3 = 8'(i);
      #1;
      chk("dbg_l3", dbg_data3, m3[i]);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
